// File: rtl/pe_cluster_ofm_collector.sv
// pe_cluster_ofm_collector: gathers per-PE OFM bytes into a bank, then streams
// the group as OUT_W-bit words over a valid/ready handshake.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   ofm_in          NUM_PE*DATA_W flattened results, PE i at [i*DATA_W +: DATA_W]
//   ofm_valid       per-PE one-cycle result strobe
//   flush           drain a partial group (missing bytes read as 0)
//   out_data        packed word, byte j of word k = PE k*BPW+j
//   out_valid       out_data valid
//   out_ready       consumer ready
//   out_last        final word of a group
//   group_done      one-cycle pulse after the last word transfers
//   group_cnt       completed group counter (wraps)
//   busy            high while draining
//   overflow        sticky duplicate/dropped-result error
//
// Build option: define OFM_SHADOW_EN to add a shadow bank that captures
// results arriving while the primary bank drains.
module pe_cluster_ofm_collector #(
    parameter int NUM_PE = 16,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PE*DATA_W-1:0] ofm_in,
    input  logic [NUM_PE-1:0]        ofm_valid,
    input  logic                     flush,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     group_done,
    output logic [15:0]              group_cnt,
    output logic                     busy,
    output logic                     overflow
);

    localparam int BPW   = OUT_W / DATA_W;
    localparam int NWORD = NUM_PE / BPW;
    localparam int KW    = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NWORD - 1);

    typedef enum logic {
        S_CAPTURE,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [NUM_PE-1:0][DATA_W-1:0] bank_q, bank_d;
    logic [NUM_PE-1:0]             mask_q, mask_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic                          done_q, done_d;
    logic                          ovf_q, ovf_d;

`ifdef OFM_SHADOW_EN
    logic [NUM_PE-1:0][DATA_W-1:0] sbank_q, sbank_d;
    logic [NUM_PE-1:0]             smask_q, smask_d;
`endif

    logic [NUM_PE-1:0][DATA_W-1:0] ofm_b;
    logic [NUM_PE-1:0]             cap_mask;
    logic                          xfer;
    logic                          xfer_last;

    assign ofm_b = ofm_in;

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        mask_d   = mask_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
`ifdef OFM_SHADOW_EN
        sbank_d  = sbank_q;
        smask_d  = smask_q;
`endif
        cap_mask  = mask_q | ofm_valid;
        xfer      = (state_q == S_DRAIN) && out_ready;
        xfer_last = xfer && (k_q == KLAST);

        unique case (state_q)
            S_CAPTURE: begin
                // First value wins; a repeat strobe only flags overflow.
                for (int i = 0; i < NUM_PE; i++) begin
                    if (ofm_valid[i]) begin
                        if (mask_q[i]) begin
                            ovf_d = 1'b1;
                        end else begin
                            bank_d[i] = ofm_b[i];
                            mask_d[i] = 1'b1;
                        end
                    end
                end
                // An empty flush has nothing to drain and is ignored.
                if ((&cap_mask) || (flush && (|cap_mask))) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                end
            end
            S_DRAIN: begin
`ifdef OFM_SHADOW_EN
                for (int i = 0; i < NUM_PE; i++) begin
                    if (ofm_valid[i]) begin
                        if (smask_q[i]) begin
                            ovf_d = 1'b1;
                        end else begin
                            sbank_d[i] = ofm_b[i];
                            smask_d[i] = 1'b1;
                        end
                    end
                end
`else
                if (|ofm_valid) begin
                    ovf_d = 1'b1;
                end
`endif
                if (xfer) begin
                    k_d = k_q + KW'(1);
                end
                if (xfer_last) begin
                    k_d     = '0;
                    state_d = S_CAPTURE;
                    mask_d  = '0;
                    cnt_d   = cnt_q + 16'd1;
                    done_d  = 1'b1;
`ifdef OFM_SHADOW_EN
                    // Shadow (including this cycle's strobes) becomes the
                    // next group; a full shadow re-drains via CAPTURE.
                    bank_d  = sbank_d;
                    mask_d  = smask_d;
                    sbank_d = '0;
                    smask_d = '0;
`endif
                end
            end
            default: begin
                state_d = S_CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CAPTURE;
            bank_q  <= '0;
            mask_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef OFM_SHADOW_EN
            sbank_q <= '0;
            smask_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            mask_q  <= mask_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
`ifdef OFM_SHADOW_EN
            sbank_q <= sbank_d;
            smask_q <= smask_d;
`endif
        end
    end

    // Bank is frozen during DRAIN, so the word holds while ready is low.
    always_comb begin
        out_data = '0;
        if (state_q == S_DRAIN) begin
            for (int j = 0; j < BPW; j++) begin
                if (mask_q[int'(k_q) * BPW + j]) begin
                    out_data[j*DATA_W +: DATA_W] = bank_q[int'(k_q) * BPW + j];
                end
            end
        end
    end

    assign out_valid  = (state_q == S_DRAIN);
    assign busy       = (state_q == S_DRAIN);
    assign out_last   = (state_q == S_DRAIN) && (k_q == KLAST);
    assign group_done = done_q;
    assign group_cnt  = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_pe_cluster_ofm_collector.sv
// tb_pe_cluster_ofm_collector: directed and random groups checked against
// a byte/mask reference model of the collector.
module tb_pe_cluster_ofm_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] ofm_in;
    logic [15:0]  ofm_valid;
    logic         flush;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         group_done;
    logic [15:0]  group_cnt;
    logic         busy;
    logic         overflow;

    always #5 clk = ~clk;

    pe_cluster_ofm_collector dut (
        .clk        (clk),
        .reset      (reset),
        .ofm_in     (ofm_in),
        .ofm_valid  (ofm_valid),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .group_done (group_done),
        .group_cnt  (group_cnt),
        .busy       (busy),
        .overflow   (overflow)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: collected bytes, which PEs reported, error flag.
    logic [7:0]  mb [16];
    logic [15:0] mm;
    logic [7:0]  sb [16];
    logic [15:0] sm;
    logic        movf;
    logic [15:0] mcnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int k);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++)
            if (mm[k*4+j]) w[j*8 +: 8] = mb[k*4+j];
        return w;
    endfunction

    function automatic logic [127:0] seq(input logic [7:0] base);
        logic [127:0] d = '0;
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = base + 8'(i);
        return d;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        mm = '0;
        sm = '0;
        movf = 1'b0;
        mcnt = '0;
        for (int i = 0; i < 16; i++) begin
            mb[i] = '0;
            sb[i] = '0;
        end
    endtask

    // One capture cycle; go = model expects DRAIN to start.
    task automatic cap(input logic [15:0] v, input logic [127:0] d,
                       input logic fl, output logic go);
        ofm_valid = v;
        ofm_in    = d;
        flush     = fl;
        out_ready = 1'b1;
        @(posedge clk); #1;
        ofm_valid = '0;
        flush     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                if (mm[i]) movf = 1'b1;
                else begin
                    mb[i] = d[i*8 +: 8];
                    mm[i] = 1'b1;
                end
            end
        end
        go = (mm == 16'hFFFF) || (fl && (mm != 16'h0));
        chk("cap_busy", 32'(busy), 32'(go));
        chk("cap_ovf", 32'(overflow), 32'(movf));
    endtask

    // Drain the group. mode 0: ready=1, 1: alternating, 2: random.
    // iv/idat are strobed on the first DRAIN cycle.
    task automatic drain(input int mode, input logic [15:0] iv,
                         input logic [127:0] idat);
        int k = 0;
        int cyc = 0;
        logic r;
        logic [15:0] v;
        while (k < 4 && cyc < 64) begin
            chk("dr_valid", 32'(out_valid), 32'd1);
            chk("dr_data", out_data, mword(k));
            chk("dr_last", 32'(out_last), 32'(k == 3));
            case (mode)
                0: r = 1'b1;
                1: r = ((cyc % 2) == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            v = (cyc == 0) ? iv : 16'h0;
            out_ready = r;
            ofm_valid = v;
            ofm_in    = idat;
            @(posedge clk); #1;
            ofm_valid = '0;
            out_ready = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (v[i]) begin
`ifdef OFM_SHADOW_EN
                    if (sm[i]) movf = 1'b1;
                    else begin
                        sb[i] = idat[i*8 +: 8];
                        sm[i] = 1'b1;
                    end
`else
                    movf = 1'b1;
`endif
                end
            end
            if (r) k++;
            cyc++;
        end
        if (k < 4) chk("dr_timeout", 32'(k), 32'd4);
        mm = '0;
`ifdef OFM_SHADOW_EN
        for (int i = 0; i < 16; i++) begin
            mb[i] = sb[i];
            sb[i] = '0;
        end
        mm = sm;
        sm = '0;
`endif
        mcnt++;
        chk("dr_done", 32'(group_done), 32'd1);
        chk("dr_cnt", 32'(group_cnt), 32'(mcnt));
        chk("dr_idle", 32'(out_valid), 32'd0);
        chk("dr_ovf", 32'(overflow), 32'(movf));
    endtask

    initial begin
        logic go;
        logic [15:0] v;
        logic [127:0] d;
        int budget;

        reset     = 1'b1;
        ofm_in    = '0;
        ofm_valid = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(group_done), 32'd0);
        chk("rst_cnt", 32'(group_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        // All PEs in one cycle.
        cap(16'hFFFF, seq(8'h01), 1'b0, go);
        chk("t1_w0", out_data, 32'h04030201);
        drain(0, 16'h0, '0);

        // One PE per cycle, PE15 first, alternating ready.
        for (int i = 15; i >= 0; i--)
            cap(16'(1 << i), seq(8'hA0), 1'b0, go);
        chk("t2_w0", out_data, 32'hA3A2A1A0);
        drain(1, 16'h0, '0);

        // Flush with nothing captured does nothing.
        cap(16'h0, '0, 1'b1, go);

        // Partial group then flush.
        cap(16'h003F, seq(8'h01), 1'b0, go);
        cap(16'h0, '0, 1'b1, go);
        chk("t4_w0", out_data, 32'h04030201);
        drain(0, 16'h0, '0);

        // Strobe on PE7 while draining.
        cap(16'hFFFF, rnd128(), 1'b0, go);
        d = '0;
        d[7*8 +: 8] = 8'h55;
        drain(0, 16'h0080, d);
`ifdef OFM_SHADOW_EN
        v = 16'hFF7F;
`else
        v = 16'hFFFF;
`endif
        cap(v, rnd128(), 1'b0, go);
        drain(2, 16'h0, '0);

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("rst2_ovf", 32'(overflow), 32'd0);

        // Duplicate strobe on PE3: first value wins.
        d = '0;
        d[3*8 +: 8] = 8'h11;
        cap(16'h0008, d, 1'b0, go);
        d[3*8 +: 8] = 8'h22;
        cap(16'h0008, d, 1'b0, go);
        cap(16'hFFF7, rnd128(), 1'b0, go);
        chk("t3_b3", 32'(out_data[31:24]), 32'h11);
        drain(2, 16'h0, '0);

        // Reset after word1 transfers.
        cap(16'hFFFF, rnd128(), 1'b0, go);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_cnt", 32'(group_cnt), 32'd0);
        cap(16'hFFFF, rnd128(), 1'b0, go);
        drain(0, 16'h0, '0);

        // Random groups.
        for (int g = 0; g < 8; g++) begin
            go = 1'b0;
            budget = 0;
            while (!go && budget < 50) begin
                v = 16'($urandom() & $urandom());
                cap(v, rnd128(), ($urandom_range(0, 9) == 0), go);
                budget++;
            end
            if (!go) chk("rnd_timeout", 32'(budget), 32'd0);
            if ((g % 3) == 0)
                drain(2, 16'($urandom() & $urandom() & $urandom()), rnd128());
            else
                drain(2, 16'h0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
